// File: rtl/rbt_idp_fix_parser_v2.sv
// IDP fix-parser, second generation.
// Two-stage, fully back-pressured pipeline: S1 decodes IDPv6 / SCMPv6
// headers, sets the PHV tags, advances SEATL and flags bounds errors.
// S2 left-aligns the transport header and drives the output stage.
// Per-class saturating statistics counters are updated on output handshake.
module rbt_idp_fix_parser_v2 #(
  parameter int HEADER_WIDTH    = 2048,
  parameter int PHV_B_NUM       = 7,
  parameter int PHV_H_NUM       = 2,
  parameter int PHV_W_NUM       = 10,
  parameter int PHV_WIDTH       = 8*PHV_B_NUM + 16*PHV_H_NUM + 32*PHV_W_NUM,
  parameter int PROTO_NO        = 0,
  parameter int SEATL_OFFSET_NO = 6,
  parameter int PKT_PROPERTY_NO = 0,
  parameter int BASE_OFFSET     = 54,
  parameter int VLAN_EXTRA      = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_proto_hdr_valid,
  output logic                    in_proto_hdr_ready,
  input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
  input  logic [15:0]             in_proto_hdr_length,
  input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
  output logic                    out_proto_hdr_valid,
  input  logic                    out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
  output logic [15:0]             out_proto_hdr_length,
  output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    cnt_idpv6,
  output logic [CNT_WIDTH-1:0]    cnt_scmpv6,
  output logic [CNT_WIDTH-1:0]    cnt_err
);

  // Bit positions of the PHV fields this block touches.
  localparam int W_LSB     = 8*PHV_B_NUM + 16*PHV_H_NUM + 32*PROTO_NO;
  localparam int SEATL_LSB = 8*SEATL_OFFSET_NO;
  localparam int PROP_LSB  = 8*PKT_PROPERTY_NO;
  // Smallest shift (in bytes) that would push the whole header out.
  localparam logic [31:0] SH_LIMIT = 32'(HEADER_WIDTH/8);

  // Tag bit positions inside the protocol word.
  localparam int TAG_VLAN   = 1;
  localparam int TAG_IDP    = 5;
  localparam int TAG_IDPV6  = 10;
  localparam int TAG_SCMPID = 11;
  localparam int TAG_NH1    = 12;
  localparam int TAG_NH2    = 13;
  localparam int TAG_NH3    = 14;
  localparam int TAG_SCMPV6 = 15;
  localparam int TAG_RECMP  = 16;
  localparam int TAG_ERR    = 31;
  localparam int PROP_NACK  = 3;
  localparam int PROP_NREP  = 4;

  // Handshake chain
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_ready;
  logic s2_ready;
  logic out_hs;

  // Header field views (first byte at the MSB)
  logic [1:0] hdr_ver;
  logic [5:0] hdr_sub;
  logic [7:0] hdr_nh;
  logic [7:0] hdr_len;
  logic [7:0] seatl;
  logic       is_idp;
  logic       has_vlan;

  // S1 decode results
  logic [PHV_WIDTH-1:0] tag_phv;
  logic [8:0]           seatl_new;
  logic [15:0]          base;
  logic [15:0]          seatl_ext;
  logic [15:0]          sh_raw;
  logic                 err_cond;

  logic [PHV_WIDTH-1:0] s1_phv_next;
  logic [15:0]          s1_sh_next;
  logic                 s1_err_next;

  // S1 registers
  logic [HEADER_WIDTH-1:0] s1_data_reg;
  logic [15:0]             s1_len_reg;
  logic [PHV_WIDTH-1:0]    s1_phv_reg;
  logic [15:0]             s1_sh_reg;
  logic                    s1_err_reg;
  logic                    s1_idp_reg;

  // S2 next / registers
  logic [HEADER_WIDTH-1:0] out_data_next;
  logic [15:0]             out_len_next;
  logic [HEADER_WIDTH-1:0] out_data_reg;
  logic [15:0]             out_len_reg;
  logic [PHV_WIDTH-1:0]    out_phv_reg;
  logic                    out_err_reg;
  logic                    out_idp_reg;

  // Counters
  logic [2:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_val [3];

  assign s2_ready = !s2_valid_reg || out_proto_hdr_ready;
  assign s1_ready = !s1_valid_reg || s2_ready;
  // Held low while reset is asserted so nothing looks accepted during reset.
  assign in_proto_hdr_ready = s1_ready && rst;
  assign out_hs = s2_valid_reg && out_proto_hdr_ready;

  assign hdr_ver  = in_proto_hdr_data[HEADER_WIDTH-1 -: 2];
  assign hdr_sub  = in_proto_hdr_data[HEADER_WIDTH-3 -: 6];
  assign hdr_nh   = in_proto_hdr_data[HEADER_WIDTH-9 -: 8];
  assign hdr_len  = in_proto_hdr_data[HEADER_WIDTH-17 -: 8];
  assign seatl    = in_proto_hdr_phv[SEATL_LSB +: 8];
  assign is_idp   = in_proto_hdr_phv[W_LSB+TAG_IDP];
  assign has_vlan = in_proto_hdr_phv[W_LSB+TAG_VLAN];

  // Classify the header, OR in the tag bits and advance SEATL past
  // IDPv6 extension headers (NH 1..3).
  always_comb begin
    tag_phv   = in_proto_hdr_phv;
    seatl_new = {1'b0, seatl};
    if (is_idp) begin
      case (hdr_ver)
        2'b00: begin
          tag_phv[W_LSB+TAG_IDPV6] = 1'b1;
          case (hdr_nh)
            8'd0: tag_phv[W_LSB+TAG_SCMPID] = 1'b1;
            8'd1: begin
              tag_phv[W_LSB+TAG_NH1] = 1'b1;
              seatl_new = {1'b0, seatl} + {1'b0, hdr_len};
            end
            8'd2: begin
              tag_phv[W_LSB+TAG_NH2] = 1'b1;
              seatl_new = {1'b0, seatl} + {1'b0, hdr_len};
            end
            8'd3: begin
              tag_phv[W_LSB+TAG_NH3] = 1'b1;
              seatl_new = {1'b0, seatl} + {1'b0, hdr_len};
            end
            default: ;
          endcase
        end
        2'b01: begin
          tag_phv[W_LSB+TAG_SCMPV6] = 1'b1;
          if (hdr_sub == 6'd1) begin
            tag_phv[W_LSB+TAG_RECMP] = 1'b1;
            if (hdr_nh == 8'd1) begin
              tag_phv[PROP_LSB+PROP_NACK] = 1'b1;
            end else if (hdr_nh == 8'd2) begin
              tag_phv[PROP_LSB+PROP_NREP] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shift amount relative to where the current header starts; every way
  // the shift can run off the header is folded into a single error flag.
  assign base      = 16'(BASE_OFFSET) + (has_vlan ? 16'(VLAN_EXTRA) : 16'd0);
  assign seatl_ext = {7'd0, seatl_new};
  assign sh_raw    = seatl_ext - base;
  assign err_cond  = seatl_new[8]
                   || (seatl_ext < base)
                   || (sh_raw > in_proto_hdr_length)
                   || ({16'd0, sh_raw} >= SH_LIMIT);

  // Final S1 PHV: error tag, or the advanced SEATL byte plus the shift.
  always_comb begin
    s1_phv_next = tag_phv;
    s1_sh_next  = 16'd0;
    s1_err_next = is_idp && err_cond;
    if (is_idp) begin
      if (err_cond) begin
        s1_phv_next[W_LSB+TAG_ERR] = 1'b1;
      end else begin
        s1_phv_next[SEATL_LSB +: 8] = seatl_new[7:0];
        s1_sh_next = sh_raw;
      end
    end
  end

  // Stage valid bits advance whenever the downstream slot can take them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s1_ready) s1_valid_reg <= in_proto_hdr_valid;
      if (s2_ready) s2_valid_reg <= s1_valid_reg;
    end
  end

  // S1 payload capture on input handshake.
  always_ff @(posedge clk) begin
    if (s1_ready && in_proto_hdr_valid) begin
      s1_data_reg <= in_proto_hdr_data;
      s1_len_reg  <= in_proto_hdr_length;
      s1_phv_reg  <= s1_phv_next;
      s1_sh_reg   <= s1_sh_next;
      s1_err_reg  <= s1_err_next;
      s1_idp_reg  <= is_idp;
    end
  end

  // Left-align the transport header; errors blank data and length.
  always_comb begin
    out_data_next = s1_data_reg << {s1_sh_reg, 3'b000};
    out_len_next  = s1_len_reg - s1_sh_reg;
    if (s1_err_reg) begin
      out_data_next = '0;
      out_len_next  = 16'd0;
    end
  end

  // Output stage; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_reg <= '0;
      out_len_reg  <= 16'd0;
      out_phv_reg  <= '0;
      out_err_reg  <= 1'b0;
      out_idp_reg  <= 1'b0;
    end else if (s2_ready && s1_valid_reg) begin
      out_data_reg <= out_data_next;
      out_len_reg  <= out_len_next;
      out_phv_reg  <= s1_phv_reg;
      out_err_reg  <= s1_err_reg;
      out_idp_reg  <= s1_idp_reg;
    end
  end

  assign out_proto_hdr_valid  = s2_valid_reg;
  assign out_proto_hdr_data   = out_data_reg;
  assign out_proto_hdr_length = out_len_reg;
  assign out_proto_hdr_phv    = out_phv_reg;

  assign cnt_inc[0] = out_hs && out_idp_reg && !out_err_reg && out_phv_reg[W_LSB+TAG_IDPV6];
  assign cnt_inc[1] = out_hs && out_idp_reg && !out_err_reg && out_phv_reg[W_LSB+TAG_SCMPV6];
  assign cnt_inc[2] = out_hs && out_err_reg;

  // One saturating counter per class; clear wins over a same-cycle increment.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Count handshaked packets of this class, stopping at all-ones.
    always_ff @(posedge clk) begin
      if (!rst || cnt_clr) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end

    assign cnt_val[gi] = cnt_reg;
  end

  assign cnt_idpv6  = cnt_val[0];
  assign cnt_scmpv6 = cnt_val[1];
  assign cnt_err    = cnt_val[2];

endmodule
